seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Sequential unsigned restoring divider: dividend / divisor -> quotient, remainder, one quotient bit per clock.
//  Inverse operation of the arithmetic multiplier blocks; the datapath block for division in the same arithmetic library.
//  Start/done handshake; results are held until the next accepted start.
// PARAMETERS
//  WIDTH  8  operand width in bits (dividend, divisor, quotient, remainder); legal range 2..32
// PORTS
//  clk          in   1      single clock; all state updates on rising edge
//  rst_n        in   1      synchronous reset, active-low
//  start        in   1      request; accepted when ready=1
//  dividend     in   WIDTH  unsigned dividend; sampled only on accepted start
//  divisor      in   WIDTH  unsigned divisor; sampled only on accepted start
//  ready        out  1      1 in IDLE and DONE (can accept start)
//  done         out  1      one-cycle pulse: quotient/remainder/div_by_zero valid
//  quotient     out  WIDTH  unsigned quotient
//  remainder    out  WIDTH  unsigned remainder
//  div_by_zero  out  1      set with done when divisor was 0
// BEHAVIOUR
//  Clock is clk; reset is synchronous, active-low (rst_n).
//  Reset (rst_n=0 at rising edge): state=IDLE, ready=1, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
//  States: IDLE, RUN, DONE.
//   IDLE/DONE + start=1: latch operands; divisor!=0 -> RUN, count=WIDTH; divisor==0 -> DONE.
//   IDLE + start=0: stay. DONE + start=0: -> IDLE (DONE lasts exactly one cycle).
//   RUN: one restoring step per cycle; count decrements; at count==1 step -> DONE.
//  Restoring step: partial remainder P is WIDTH+1 bits; P' = {P[WIDTH-1:0], Q[WIDTH-1]}; Q <<= 1;
//   T = P' - {1'b0,divisor}; T[WIDTH]==0 -> P=T, Q[0]=1; else P=P', Q[0]=0. Initial P=0, Q=dividend.
//  Latency: start accepted at edge 0 -> done=1 during cycle WIDTH+1 (WIDTH RUN cycles + DONE).
//   Divide-by-zero: done=1 in the cycle after acceptance; quotient=all ones, remainder=dividend, div_by_zero=1.
//  quotient/remainder/div_by_zero update only on entry to DONE; held stable through IDLE until the next DONE.
//  div_by_zero cleared on next accepted start.
//  start while in RUN (ready=0): ignored, no effect on operation or operands.
//  start in the DONE cycle: accepted (back-to-back); done pulse still shown that cycle.
//  Operand inputs changing during RUN: no effect (latched copies used).
//  rst_n=0 mid-RUN: abort, reset values above next cycle, no done pulse.
//  Invariant at done (divisor!=0): quotient*divisor + remainder == dividend, remainder < divisor.
// STRUCTURE
//  Shared package/include: state encoding localparams (ST_IDLE, ST_RUN, ST_DONE), counter width
//   $clog2(WIDTH+1) helper, used by the divider and its bench.
//  One sub-module: div_step (combinational restoring step: P, Q, divisor -> P', Q'), WIDTH-parameterised.
//  Top holds FSM, counter, operand/result registers.
// TESTING
//  WIDTH=8, 200/7 -> done at cycle 9 after start, quotient=28, remainder=4, div_by_zero=0.
//  5/0 -> done in cycle 1, quotient=255, remainder=5, div_by_zero=1.
//  255/1 -> quotient=255, remainder=0; 3/10 -> quotient=0, remainder=3; 0/9 -> 0, 0.
//  200/7 started, start=1 with 100/3 at cycle 4 -> ignored; result still 28 r 4; ready=0 cycles 1-8.
//  start with 100/3 held during DONE cycle of 200/7 -> accepted; next done 9 cycles later, 33 r 1.
//  rst_n=0 at cycle 5 of RUN -> next cycle IDLE, outputs zero, no done; random 1000-pair check of invariant.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and counter sizing used by the RTL and its bench.
package seq_divider_pkg;
   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   // Counter must hold the value WIDTH itself, not just WIDTH-1.
   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction
endpackage

// File: rtl/seq_divider_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference if it did not go negative.
module div_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH:0]   p_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH:0]   p_o,
   output logic [WIDTH-1:0] q_o
);
   logic [WIDTH:0] p_sh;
   logic [WIDTH:0] trial;

   always_comb begin
      p_sh  = {p_i[WIDTH-1:0], q_i[WIDTH-1]};
      trial = p_sh - {1'b0, divisor_i};
      if (!trial[WIDTH]) begin
         p_o = trial;
         q_o = {q_i[WIDTH-2:0], 1'b1};
      end else begin
         p_o = p_sh;
         q_o = {q_i[WIDTH-2:0], 1'b0};
      end
   end
endmodule

// File: rtl/seq_divider.sv
// Unsigned sequential restoring divider, one quotient bit per clock, with a
// start/done handshake; results hold until the next completed division.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);
   localparam int CW = cnt_w(WIDTH);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   p_q, p_d, p_nxt;
   logic [WIDTH-1:0] q_q, q_d, q_nxt;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
   logic             dbz_q, dbz_d;
   logic             accept, last_step;

   div_step #(.WIDTH(WIDTH)) u_step (
      .p_i       (p_q),
      .q_i       (q_q),
      .divisor_i (dvs_q),
      .p_o       (p_nxt),
      .q_o       (q_nxt)
   );

   assign accept    = ready && start;
   assign last_step = (state_q == ST_RUN) && (cnt_q == CW'(1));

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start)                  state_d = (divisor == '0) ? ST_DONE : ST_RUN;
            else if (state_q == ST_DONE) state_d = ST_IDLE;
         end
         ST_RUN:  if (cnt_q == CW'(1)) state_d = ST_DONE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
      done  = (state_q == ST_DONE);
   end

   // Results only change on entry to DONE; divide-by-zero skips RUN entirely.
   always_comb begin
      cnt_d  = cnt_q;
      p_d    = p_q;
      q_d    = q_q;
      dvs_d  = dvs_q;
      quot_d = quot_q;
      rem_d  = rem_q;
      dbz_d  = dbz_q;
      if (accept) begin
         dvs_d = divisor;
         p_d   = '0;
         q_d   = dividend;
         dbz_d = (divisor == '0);
         if (divisor == '0) begin
            cnt_d  = '0;
            quot_d = '1;
            rem_d  = dividend;
         end else begin
            cnt_d = CW'(WIDTH);
         end
      end else if (state_q == ST_RUN) begin
         p_d   = p_nxt;
         q_d   = q_nxt;
         cnt_d = cnt_q - CW'(1);
         if (last_step) begin
            quot_d = q_nxt;
            rem_d  = p_nxt[WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         p_q    <= '0;
         q_q    <= '0;
         dvs_q  <= '0;
         quot_q <= '0;
         rem_q  <= '0;
         dbz_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         p_q    <= p_d;
         q_q    <= q_d;
         dvs_q  <= dvs_d;
         quot_q <= quot_d;
         rem_q  <= rem_d;
         dbz_q  <= dbz_d;
      end
   end

   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider (WIDTH=8): directed corner cases plus random operand
// pairs checked against plain integer division.
module tb_seq_divider;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n, start;
   logic [W-1:0] dividend, divisor, quotient, remainder;
   logic         ready, done, div_by_zero;
   int           n_assert = 0;
   int           n_fail = 0;

   always #5 clk = ~clk;

   seq_divider #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
      .ready(ready), .done(done), .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic launch(input int a, input int b);
      start = 1'b1; dividend = W'(a); divisor = W'(b);
      tick();
      start = 1'b0;
      dividend = W'($urandom); divisor = W'($urandom);
   endtask

   // Called in cycle 1 after acceptance; returns the cycle in which done was seen.
   task automatic wait_done(input string tag, output int cyc);
      cyc = 1;
      while (!done && cyc < 40) begin
         chk({tag, "_ready_busy"}, 32'(ready), 0);
         tick();
         cyc++;
      end
      if (!done) chk({tag, "_timeout"}, 32'(done), 1);
   endtask

   task automatic check_div(input string tag, input int a, input int b);
      int cyc, eq, er, ez;
      eq = (b == 0) ? 255 : a / b;
      er = (b == 0) ? a : a % b;
      ez = (b == 0) ? 1 : 0;
      launch(a, b);
      wait_done(tag, cyc);
      chk({tag, "_lat"}, 32'(cyc), 32'((b == 0) ? 1 : W + 1));
      chk({tag, "_q"}, 32'(quotient), 32'(eq));
      chk({tag, "_r"}, 32'(remainder), 32'(er));
      chk({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
      if (b != 0) begin
         chk({tag, "_inv"}, 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
         chk({tag, "_rlt"}, 32'(32'(remainder) < 32'(b)), 1);
      end
      tick();
      chk({tag, "_done_clr"}, 32'(done), 0);
      chk({tag, "_hold_q"}, 32'(quotient), 32'(eq));
   endtask

   initial begin
      int cyc, a, b;
      rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
      tick(); tick();
      chk("rst_ready", 32'(ready), 1);
      chk("rst_done", 32'(done), 0);
      chk("rst_q", 32'(quotient), 0);
      chk("rst_r", 32'(remainder), 0);
      chk("rst_dbz", 32'(div_by_zero), 0);
      rst_n = 1'b1;
      tick();

      check_div("d200_7", 200, 7);
      check_div("d5_0", 5, 0);
      check_div("d255_1", 255, 1);
      check_div("d3_10", 3, 10);
      check_div("d0_9", 0, 9);

      // start during RUN must be ignored
      launch(200, 7);
      for (int c = 1; c <= 8; c++) begin
         chk("ign_ready", 32'(ready), 0);
         chk("ign_done", 32'(done), 0);
         if (c == 4) begin start = 1'b1; dividend = 8'd100; divisor = 8'd3; end
         else start = 1'b0;
         tick();
      end
      start = 1'b0;
      chk("ign_done9", 32'(done), 1);
      chk("ign_q", 32'(quotient), 28);
      chk("ign_r", 32'(remainder), 4);
      tick();

      // back-to-back start in the DONE cycle
      launch(200, 7);
      for (int c = 1; c <= 8; c++) tick();
      chk("b2b_done1", 32'(done), 1);
      chk("b2b_q1", 32'(quotient), 28);
      launch(100, 3);
      wait_done("b2b", cyc);
      chk("b2b_lat", 32'(cyc), W + 1);
      chk("b2b_q2", 32'(quotient), 33);
      chk("b2b_r2", 32'(remainder), 1);
      tick();

      // reset in the middle of RUN aborts without a done pulse
      launch(200, 7);
      for (int c = 1; c < 5; c++) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("abort_ready", 32'(ready), 1);
      chk("abort_done", 32'(done), 0);
      chk("abort_q", 32'(quotient), 0);
      chk("abort_r", 32'(remainder), 0);
      chk("abort_dbz", 32'(div_by_zero), 0);
      for (int c = 0; c < 12; c++) begin
         chk("abort_nodone", 32'(done), 0);
         tick();
      end

      for (int i = 0; i < 1000; i++) begin
         a = int'($urandom_range(0, 255));
         b = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 255));
         check_div("rnd", a, b);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
